// File: rtl/note_voice_mixer.sv
// Seven-voice square-wave tone generator with attack/release envelopes, a saturating
// mixer and a decimated sample stage feeding the Audio_Controller write port.
module note_voice_mixer #(
  parameter int unsigned HP_C       = 96000,
  parameter int unsigned HP_D       = 86000,
  parameter int unsigned HP_E       = 76000,
  parameter int unsigned HP_F       = 71500,
  parameter int unsigned HP_G       = 64000,
  parameter int unsigned HP_A       = 57000,
  parameter int unsigned HP_B       = 51000,
  parameter int unsigned AMPLITUDE  = 100000000,
  parameter int unsigned ENV_STEP   = 1000000,
  parameter int unsigned ENV_DIV    = 500,
  parameter int unsigned SAMPLE_DIV = 1042
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  note_on,
  input  logic        audio_out_allowed,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic [6:0]  voice_active,
  output logic [15:0] drop_count
);

  localparam int ENV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam int SMP_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic signed [34:0] SAT_HI = 35'sd2147483647;
  localparam logic signed [34:0] SAT_LO = -35'sd2147483648;

  // Voice index follows note_on bit order: 0 = B .. 6 = C.
  function automatic logic [31:0] hp_last(input int idx);
    case (idx)
      0:       return HP_B - 1;
      1:       return HP_A - 1;
      2:       return HP_G - 1;
      3:       return HP_F - 1;
      4:       return HP_E - 1;
      5:       return HP_D - 1;
      default: return HP_C - 1;
    endcase
  endfunction

  logic [ENV_W-1:0]   env_cnt;
  logic [SMP_W-1:0]   smp_cnt;
  logic               env_tick;
  logic               smp_strobe;
  logic [31:0]        phase [7];
  logic [31:0]        amp [7];
  logic [6:0]         sign;
  logic [32:0]        up_w [7];
  logic [32:0]        dn_w [7];
  logic [31:0]        amp_up [7];
  logic [31:0]        amp_dn [7];
  logic signed [31:0] voice [7];
  logic signed [34:0] sum;
  logic [31:0]        mix_d;
  logic [31:0]        mix_q;
  logic [31:0]        sample_q;
  logic [6:0]         amp_nz;
  logic               pending;
  logic               grant;

  assign env_tick   = (env_cnt == ENV_W'(ENV_DIV - 1));
  assign smp_strobe = (smp_cnt == SMP_W'(SAMPLE_DIV - 1));

  // Handshake: a captured sample is offered while pending is high. It is taken on an
  // edge where audio_out_allowed is high and no write was issued on the previous edge;
  // write_audio_out is then high for the following cycle with the channels carrying it.
  assign grant = pending && audio_out_allowed && !write_audio_out;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 7; i++) begin
      up_w[i]   = {1'b0, amp[i]} + 33'(ENV_STEP);
      dn_w[i]   = {1'b0, amp[i]} - 33'(ENV_STEP);
      amp_up[i] = (up_w[i] > 33'(AMPLITUDE)) ? 32'(AMPLITUDE) : up_w[i][31:0];
      amp_dn[i] = dn_w[i][32] ? 32'd0 : dn_w[i][31:0];
      voice[i]  = sign[i] ? -$signed(amp[i]) : $signed(amp[i]);
      amp_nz[i] = (amp[i] != 32'd0);
      sum       = sum + $signed({{3{voice[i][31]}}, voice[i]});
    end
    if (sum > SAT_HI)      mix_d = 32'h7FFF_FFFF;
    else if (sum < SAT_LO) mix_d = 32'h8000_0000;
    else                   mix_d = sum[31:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      env_cnt                 <= '0;
      smp_cnt                 <= '0;
      sign                    <= '0;
      mix_q                   <= '0;
      sample_q                <= '0;
      pending                 <= 1'b0;
      write_audio_out         <= 1'b0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
      voice_active            <= '0;
      drop_count              <= '0;
      for (int i = 0; i < 7; i++) begin
        phase[i] <= '0;
        amp[i]   <= '0;
      end
    end else begin
      env_cnt <= env_tick ? '0 : env_cnt + ENV_W'(1);
      smp_cnt <= smp_strobe ? '0 : smp_cnt + SMP_W'(1);

      for (int i = 0; i < 7; i++) begin
        if (voice_active[i] || note_on[i]) begin
          if (phase[i] == hp_last(i)) begin
            phase[i] <= '0;
            sign[i]  <= ~sign[i];
          end else begin
            phase[i] <= phase[i] + 32'd1;
          end
        end else begin
          phase[i] <= '0;
          sign[i]  <= 1'b0;
        end
        if (env_tick) amp[i] <= note_on[i] ? amp_up[i] : amp_dn[i];
      end

      voice_active    <= amp_nz;
      mix_q           <= mix_d;
      write_audio_out <= grant;
      if (grant) begin
        left_channel_audio_out  <= sample_q;
        right_channel_audio_out <= sample_q;
      end

      // A strobe always captures; it only counts as a loss if the old sample is not leaving now.
      if (smp_strobe) begin
        sample_q <= mix_q;
        pending  <= 1'b1;
        if (pending && !grant && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end else if (grant) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_note_voice_mixer.sv
// Scoreboard bench: four note_voice_mixer instances with test-sized parameters; stimulus
// pushes hand-computed samples into per-instance queues, a monitor pops them on each write.
module tb_note_voice_mixer;

  logic        clock;
  logic        rst [4];
  logic [6:0]  note [4];
  logic        allowed [4];
  logic        wr [4];
  logic [31:0] lch [4];
  logic [31:0] rch [4];
  logic [6:0]  va [4];
  logic [15:0] drop [4];

  logic [31:0] exp_q [4][$];
  logic        prev_wr [4];
  int          total = 0;
  int          bad = 0;

  localparam logic [31:0] P1K  = 32'd1000;
  localparam logic [31:0] N1K  = -32'sd1000;
  localparam logic [31:0] SMAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  // dut 0: single tone on C, also used for reset and drop saturation
  note_voice_mixer #(.HP_C(4), .AMPLITUDE(1000), .ENV_STEP(1000), .ENV_DIV(1), .SAMPLE_DIV(1)) u_tone (
    .clock(clock), .reset(rst[0]), .note_on(note[0]), .audio_out_allowed(allowed[0]),
    .write_audio_out(wr[0]), .left_channel_audio_out(lch[0]), .right_channel_audio_out(rch[0]),
    .voice_active(va[0]), .drop_count(drop[0]));

  // dut 1: release ramp on D, half-period long enough that the sign never flips
  note_voice_mixer #(.HP_D(1000), .AMPLITUDE(1000), .ENV_STEP(250), .ENV_DIV(2), .SAMPLE_DIV(1)) u_rel (
    .clock(clock), .reset(rst[1]), .note_on(note[1]), .audio_out_allowed(allowed[1]),
    .write_audio_out(wr[1]), .left_channel_audio_out(lch[1]), .right_channel_audio_out(rch[1]),
    .voice_active(va[1]), .drop_count(drop[1]));

  // dut 2: backpressure, coincident strobe/grant, reset while pending
  note_voice_mixer #(.AMPLITUDE(1000), .ENV_STEP(1000), .ENV_DIV(1), .SAMPLE_DIV(8)) u_bp (
    .clock(clock), .reset(rst[2]), .note_on(note[2]), .audio_out_allowed(allowed[2]),
    .write_audio_out(wr[2]), .left_channel_audio_out(lch[2]), .right_channel_audio_out(rch[2]),
    .voice_active(va[2]), .drop_count(drop[2]));

  // dut 3: all seven voices at 2^30 in phase, forcing the mixer clamp
  note_voice_mixer #(.HP_C(10), .HP_D(10), .HP_E(10), .HP_F(10), .HP_G(10), .HP_A(10), .HP_B(10),
    .AMPLITUDE(1073741824), .ENV_STEP(1073741824), .ENV_DIV(1), .SAMPLE_DIV(1)) u_sat (
    .clock(clock), .reset(rst[3]), .note_on(note[3]), .audio_out_allowed(allowed[3]),
    .write_audio_out(wr[3]), .left_channel_audio_out(lch[3]), .right_channel_audio_out(rch[3]),
    .voice_active(va[3]), .drop_count(drop[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic wait_drain(input int k, input int budget);
    int n = 0;
    while (exp_q[k].size() != 0 && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    total++;
    if (exp_q[k].size() != 0) begin
      bad++;
      $display("FAIL drain_dut%0d: %0d samples still expected after %0d cycles, want 0", k, exp_q[k].size(), budget);
      exp_q[k].delete();
    end
  endtask

  always @(negedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (wr[k] === 1'b1) begin
        check($sformatf("no_back_to_back_dut%0d", k), {31'b0, prev_wr[k]}, 32'd0);
        if (exp_q[k].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write_dut%0d: got write with data %0d, want no write", k, $signed(lch[k]));
        end else begin
          logic [31:0] e;
          e = exp_q[k].pop_front();
          check($sformatf("left_dut%0d", k), lch[k], e);
          check($sformatf("right_dut%0d", k), rch[k], e);
        end
      end
      prev_wr[k] = (wr[k] === 1'b1);
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1;
      note[k] = 7'h00;
      allowed[k] = 1'b0;
      prev_wr[k] = 1'b0;
    end
    repeat (2) @(posedge clock);

    // Reset holds everything at zero even with all keys down and the FIFO open
    @(negedge clock);
    note[0] = 7'h7F;
    allowed[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      @(negedge clock);
      check("rst_write", {31'b0, wr[0]}, 32'd0);
      check("rst_left", lch[0], 32'd0);
      check("rst_right", rch[0], 32'd0);
      check("rst_voice_active", {25'b0, va[0]}, 32'd0);
      check("rst_drop", {16'b0, drop[0]}, 32'd0);
    end
    rst[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("post_rst_write", {31'b0, wr[0]}, 32'd0);
    check("post_rst_left", lch[0], 32'd0);
    check("post_rst_voice_active", {25'b0, va[0]}, 32'd0);
    check("post_rst_drop", {16'b0, drop[0]}, 32'd0);

    // Single tone on C: writes every other cycle, two +1000 then two -1000
    rst[0] = 1'b1;
    note[0] = 7'h40;
    exp_q[0].push_back(32'd0);
    for (int r = 0; r < 3; r++) begin
      exp_q[0].push_back(P1K);
      exp_q[0].push_back(P1K);
      exp_q[0].push_back(N1K);
      exp_q[0].push_back(N1K);
    end
    @(posedge clock);
    @(negedge clock);
    rst[0] = 1'b0;
    wait_drain(0, 60);
    allowed[0] = 1'b0;
    check("tone_voice_active", {25'b0, va[0]}, 32'h40);

    // Release ramp on D: attack 250/tick to 1000, then release back to 0
    @(negedge clock);
    note[1] = 7'h20;
    allowed[1] = 1'b1;
    exp_q[1].push_back(32'd0);
    exp_q[1].push_back(32'd0);
    exp_q[1].push_back(32'd250);
    exp_q[1].push_back(32'd500);
    exp_q[1].push_back(32'd750);
    exp_q[1].push_back(32'd1000);
    exp_q[1].push_back(32'd1000);
    exp_q[1].push_back(32'd750);
    exp_q[1].push_back(32'd500);
    exp_q[1].push_back(32'd250);
    exp_q[1].push_back(32'd0);
    @(posedge clock);
    @(negedge clock);
    rst[1] = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    note[1] = 7'h00;
    repeat (8) @(posedge clock);
    @(negedge clock);
    check("release_active_at_zero_edge", {25'b0, va[1]}, 32'h20);
    @(negedge clock);
    check("release_inactive_after", {25'b0, va[1]}, 32'h00);
    wait_drain(1, 20);
    allowed[1] = 1'b0;

    // Backpressure: strobes every 8 cycles, FIFO closed for three of them
    @(negedge clock);
    note[2] = 7'h01;
    @(posedge clock);
    @(negedge clock);
    rst[2] = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock);
    check("bp_drop_strobe1", {16'b0, drop[2]}, 32'd0);
    repeat (8) @(posedge clock);
    @(negedge clock);
    check("bp_drop_strobe2", {16'b0, drop[2]}, 32'd1);
    repeat (8) @(posedge clock);
    @(negedge clock);
    check("bp_drop_strobe3", {16'b0, drop[2]}, 32'd2);
    allowed[2] = 1'b1;
    exp_q[2].push_back(P1K);
    wait_drain(2, 5);
    allowed[2] = 1'b0;

    // Grant lands on a strobe edge: old sample written, new one stays pending
    repeat (14) @(posedge clock);
    @(negedge clock);
    allowed[2] = 1'b1;
    exp_q[2].push_back(P1K);
    exp_q[2].push_back(P1K);
    @(posedge clock);
    @(negedge clock);
    check("coincident_drop_unchanged", {16'b0, drop[2]}, 32'd2);
    wait_drain(2, 10);
    allowed[2] = 1'b0;

    // Reset while a sample is pending: it must never be written
    repeat (6) @(posedge clock);
    @(negedge clock);
    rst[2] = 1'b1;
    allowed[2] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rst[2] = 1'b0;
    check("reset_pending_drop", {16'b0, drop[2]}, 32'd0);
    repeat (6) @(posedge clock);
    @(negedge clock);
    allowed[2] = 1'b0;

    // Saturation: seven in-phase voices at 2^30 clamp to the 32-bit limits
    note[3] = 7'h7F;
    allowed[3] = 1'b1;
    exp_q[3].push_back(32'd0);
    repeat (5) exp_q[3].push_back(SMAX);
    repeat (5) exp_q[3].push_back(SMIN);
    repeat (2) exp_q[3].push_back(SMAX);
    @(posedge clock);
    @(negedge clock);
    rst[3] = 1'b0;
    wait_drain(3, 80);
    allowed[3] = 1'b0;
    check("sat_voice_active", {25'b0, va[3]}, 32'h7F);

    // Drop counter saturation: tone instance strobes every cycle with the FIFO closed
    repeat (65540) @(posedge clock);
    @(negedge clock);
    check("drop_saturated", {16'b0, drop[0]}, 32'h0000_FFFF);
    repeat (20) @(posedge clock);
    @(negedge clock);
    check("drop_stays_saturated", {16'b0, drop[0]}, 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
